// File: rtl/lsu_queue_if.sv
`default_nettype none
// ============================================================================
// lsu_queue_if : request / dmem / response bundle of the lsu_queue block
// Revision 1.0
// ============================================================================
interface lsu_queue_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int FETCH_WIDTH = 64,
  parameter int TAG_WIDTH   = 4
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_store_i;
  logic [2:0]             req_funct3_i;
  logic [DATA_WIDTH-1:0]  req_base_i;
  logic [11:0]            req_imm_i;
  logic [DATA_WIDTH-1:0]  req_data_i;
  logic [TAG_WIDTH-1:0]   req_tag_i;
  logic                   flush_i;
  logic                   dmem_busy_i;
  logic                   dmem_rdy_i;
  logic [FETCH_WIDTH-1:0] dmem_rd_data_i;
  logic                   dmem_rd_en_o;
  logic                   dmem_wr_en_o;
  logic [DATA_WIDTH-1:0]  dmem_addr_o;
  logic [1:0]             dmem_wr_size_o;
  logic [FETCH_WIDTH-1:0] dmem_wr_data_o;
  logic                   resp_valid_o;
  logic                   resp_ready_i;
  logic [TAG_WIDTH-1:0]   resp_tag_o;
  logic [DATA_WIDTH-1:0]  resp_data_o;
  logic                   resp_fault_o;
  logic                   resp_store_o;
  logic                   empty_o;

  modport master (
    output req_valid_i, req_store_i, req_funct3_i, req_base_i, req_imm_i,
           req_data_i, req_tag_i, flush_i, dmem_busy_i, dmem_rdy_i,
           dmem_rd_data_i, resp_ready_i,
    input  req_ready_o, dmem_rd_en_o, dmem_wr_en_o, dmem_addr_o,
           dmem_wr_size_o, dmem_wr_data_o, resp_valid_o, resp_tag_o,
           resp_data_o, resp_fault_o, resp_store_o, empty_o
  );

  modport slave (
    input  req_valid_i, req_store_i, req_funct3_i, req_base_i, req_imm_i,
           req_data_i, req_tag_i, flush_i, dmem_busy_i, dmem_rdy_i,
           dmem_rd_data_i, resp_ready_i,
    output req_ready_o, dmem_rd_en_o, dmem_wr_en_o, dmem_addr_o,
           dmem_wr_size_o, dmem_wr_data_o, resp_valid_o, resp_tag_o,
           resp_data_o, resp_fault_o, resp_store_o, empty_o
  );
endinterface
`default_nettype wire

// File: rtl/lsu_queue.sv
`default_nettype none
// ============================================================================
// lsu_queue : in-order tagged load/store queue with one outstanding dmem access
// Revision 1.0
// ============================================================================
module lsu_queue #(
  parameter int DATA_WIDTH  = 64,
  parameter int FETCH_WIDTH = 64,
  parameter int DEPTH       = 4,
  parameter int TAG_WIDTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  lsu_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic                  q_store  [DEPTH];
  logic [2:0]            q_funct3 [DEPTH];
  logic [DATA_WIDTH-1:0] q_addr   [DEPTH];
  logic [DATA_WIDTH-1:0] q_data   [DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag    [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_fault_q;

  logic                  head_valid;
  logic                  head_store;
  logic [2:0]            head_funct3;
  logic [DATA_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic                  not_full;
  logic                  enq;
  logic                  deq;
  logic [DATA_WIDTH-1:0] enq_addr;
  logic                  misaligned;
  logic                  illegal;
  logic                  fault;
  logic                  issue_go;
  logic [DATA_WIDTH-1:0] rd_raw;
  logic [DATA_WIDTH-1:0] load_fmt;

  assign head_valid  = (count != '0);
  assign head_store  = q_store[rd_ptr];
  assign head_funct3 = q_funct3[rd_ptr];
  assign head_addr   = q_addr[rd_ptr];
  assign head_data   = q_data[rd_ptr];
  assign head_tag    = q_tag[rd_ptr];

  // A flush claims the cycle: no enqueue and no pop can happen alongside it.
  assign not_full = (count != FULL_COUNT);
  assign enq      = bus.req_valid_i && not_full && !bus.flush_i;
  assign deq      = (state == S_RESP) && bus.resp_ready_i && !bus.flush_i;
  assign enq_addr = bus.req_base_i + {{(DATA_WIDTH-12){bus.req_imm_i[11]}}, bus.req_imm_i};

  always_comb begin
    misaligned = 1'b0;
    case (head_funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = head_addr[0];
      2'd2:    misaligned = |head_addr[1:0];
      default: misaligned = |head_addr[2:0];
    endcase
  end

  assign illegal = head_store ? head_funct3[2] : (head_funct3 == 3'd7);
  assign fault   = misaligned || illegal;

  // Strobe only in the first non-busy ISSUE cycle; flush or reset suppress it.
  assign issue_go = (state == S_ISSUE) && !bus.dmem_busy_i && !bus.flush_i && rst;

  assign rd_raw = bus.dmem_rd_data_i[DATA_WIDTH-1:0];

  always_comb begin
    load_fmt = rd_raw;
    case (head_funct3)
      3'd0:    load_fmt = {{(DATA_WIDTH-8){rd_raw[7]}},   rd_raw[7:0]};
      3'd1:    load_fmt = {{(DATA_WIDTH-16){rd_raw[15]}}, rd_raw[15:0]};
      3'd2:    load_fmt = {{(DATA_WIDTH-32){rd_raw[31]}}, rd_raw[31:0]};
      3'd4:    load_fmt = {{(DATA_WIDTH-8){1'b0}},  rd_raw[7:0]};
      3'd5:    load_fmt = {{(DATA_WIDTH-16){1'b0}}, rd_raw[15:0]};
      3'd6:    load_fmt = {{(DATA_WIDTH-32){1'b0}}, rd_raw[31:0]};
      default: load_fmt = rd_raw;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!bus.flush_i && head_valid)
          state_nxt = fault ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.flush_i)
          state_nxt = S_IDLE;
        else if (!bus.dmem_busy_i)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A completion landing with the flush needs no draining.
        if (bus.flush_i)
          state_nxt = bus.dmem_rdy_i ? S_IDLE : S_DRAIN;
        else if (bus.dmem_rdy_i)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.flush_i || bus.resp_ready_i)
          state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.dmem_rdy_i)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq)
          wr_ptr <= wr_ptr + 1'b1;
        if (deq)
          rd_ptr <= rd_ptr + 1'b1;
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if ((state == S_IDLE) && head_valid && !bus.flush_i) begin
        resp_fault_q <= fault;
        resp_data_q  <= '0;
      end else if ((state == S_WAIT) && bus.dmem_rdy_i && !bus.flush_i) begin
        resp_data_q <= head_store ? '0 : load_fmt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_store[wr_ptr]  <= bus.req_store_i;
      q_funct3[wr_ptr] <= bus.req_funct3_i;
      q_addr[wr_ptr]   <= enq_addr;
      q_data[wr_ptr]   <= bus.req_data_i;
      q_tag[wr_ptr]    <= bus.req_tag_i;
    end
  end

  generate
    if (FETCH_WIDTH == DATA_WIDTH) begin : g_wdata_full
      assign bus.dmem_wr_data_o = head_data;
    end else begin : g_wdata_ext
      assign bus.dmem_wr_data_o = {{(FETCH_WIDTH-DATA_WIDTH){1'b0}}, head_data};
    end
  endgenerate

  assign bus.req_ready_o    = not_full;
  assign bus.dmem_rd_en_o   = issue_go && !head_store;
  assign bus.dmem_wr_en_o   = issue_go && head_store;
  assign bus.dmem_addr_o    = head_addr;
  assign bus.dmem_wr_size_o = head_funct3[1:0];
  assign bus.resp_valid_o   = (state == S_RESP);
  assign bus.resp_tag_o     = head_tag;
  assign bus.resp_data_o    = resp_data_q;
  assign bus.resp_fault_o   = resp_fault_q;
  assign bus.resp_store_o   = head_store;
  assign bus.empty_o        = (count == '0) && (state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lsu_queue.sv
`default_nettype none
// ============================================================================
// tb_lsu_queue : directed scoreboard bench for lsu_queue with a byte memory model
// Revision 1.0
// ============================================================================
module tb_lsu_queue;
  localparam int DW    = 64;
  localparam int FW    = 64;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_queue_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .TAG_WIDTH(TW)) bus ();

  lsu_queue #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          fault;
    logic          store;
  } resp_t;

  resp_t       exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  mem [logic [63:0]];
  int          strobes    = 0;
  int          wr_strobes = 0;
  int          mem_lat    = 1;
  logic [63:0] last_addr  = '0;
  logic [63:0] last_wdata = '0;
  logic [1:0]  last_size  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic st, input logic [2:0] f3, input logic [63:0] base,
                      input logic [11:0] imm, input logic [63:0] data, input logic [TW-1:0] tag);
    int n;
    n = 0;
    bus.req_store_i  = st;
    bus.req_funct3_i = f3;
    bus.req_base_i   = base;
    bus.req_imm_i    = imm;
    bus.req_data_i   = data;
    bus.req_tag_i    = tag;
    bus.req_valid_i  = 1'b1;
    while (!bus.req_ready_o && n < 50) begin
      tick();
      n++;
    end
    check("send_ready_timeout", 64'(bus.req_ready_o), 64'd1);
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.empty_o && n < 200) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", 64'(bus.empty_o), 64'd1);
  endtask

  function automatic resp_t mk(input logic [TW-1:0] tag, input logic [63:0] data,
                               input logic fault, input logic store);
    resp_t r;
    r.tag = tag; r.data = data; r.fault = fault; r.store = store;
    return r;
  endfunction

  // Response monitor: every handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    if (rst && !bus.flush_i && bus.resp_valid_o && bus.resp_ready_i) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_resp observed tag=%h expected=none", bus.resp_tag_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_tag",   64'(bus.resp_tag_o),   64'(e.tag));
        check("resp_data",  bus.resp_data_o,       e.data);
        check("resp_fault", 64'(bus.resp_fault_o), 64'(e.fault));
        check("resp_store", 64'(bus.resp_store_o), 64'(e.store));
      end
    end
  end

  // Data memory model: completes each strobed access mem_lat cycles later.
  initial begin
    logic [63:0] a;
    logic [63:0] rd;
    int          lat;
    bus.dmem_rdy_i     = 1'b0;
    bus.dmem_rd_data_i = '0;
    forever begin
      @(negedge clk);
      if (bus.dmem_rd_en_o || bus.dmem_wr_en_o) begin
        a = bus.dmem_addr_o;
        strobes++;
        last_addr = a;
        if (bus.dmem_wr_en_o) begin
          wr_strobes++;
          last_size  = bus.dmem_wr_size_o;
          last_wdata = bus.dmem_wr_data_o;
          for (int i = 0; i < (1 << last_size); i++)
            mem[a + 64'(i)] = last_wdata[8*i +: 8];
        end
        rd = '0;
        for (int i = 0; i < 8; i++)
          if (mem.exists(a + 64'(i))) rd[8*i +: 8] = mem[a + 64'(i)];
        lat = mem_lat;
        repeat (lat) @(posedge clk);
        #1;
        bus.dmem_rdy_i     = 1'b1;
        bus.dmem_rd_data_i = rd;
        @(posedge clk);
        #1;
        bus.dmem_rdy_i = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int w0;
    rst              = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_store_i  = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_base_i   = '0;
    bus.req_imm_i    = '0;
    bus.req_data_i   = '0;
    bus.req_tag_i    = '0;
    bus.flush_i      = 1'b0;
    bus.dmem_busy_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    mem[64'h0FFF] = 8'h80;
    mem[64'h2004] = 8'h01;
    mem[64'h2005] = 8'h00;
    mem[64'h2006] = 8'h00;
    mem[64'h2007] = 8'h80;

    repeat (2) tick();
    check("rst_req_ready",  64'(bus.req_ready_o),  64'd1);
    check("rst_rd_en",      64'(bus.dmem_rd_en_o), 64'd0);
    check("rst_wr_en",      64'(bus.dmem_wr_en_o), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rst_resp_fault", 64'(bus.resp_fault_o), 64'd0);
    check("rst_empty",      64'(bus.empty_o),      64'd1);
    rst = 1'b1;
    tick();

    // LB with negative offset, cycle-exact latency
    exp_q.push_back(mk(4'd5, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0));
    send(1'b0, 3'd0, 64'h1000, 12'hFFF, 64'd0, 4'd5);
    tick();
    check("lb_strobe",   64'(bus.dmem_rd_en_o), 64'd1);
    check("lb_addr",     bus.dmem_addr_o,       64'h0FFF);
    tick();
    check("lb_single_strobe", 64'(bus.dmem_rd_en_o), 64'd0);
    check("lb_not_yet_valid", 64'(bus.resp_valid_o), 64'd0);
    tick();
    check("lb_latency_valid", 64'(bus.resp_valid_o), 64'd1);
    wait_idle();

    // LWU then SD
    w0 = wr_strobes;
    exp_q.push_back(mk(4'd1, 64'h0000_0000_8000_0001, 1'b0, 1'b0));
    send(1'b0, 3'd6, 64'h2000, 12'd4, 64'd0, 4'd1);
    exp_q.push_back(mk(4'd2, 64'd0, 1'b0, 1'b1));
    send(1'b1, 3'd3, 64'h2000, 12'd8, 64'h1122_3344_5566_7788, 4'd2);
    wait_idle();
    check("sd_wr_count", 64'(wr_strobes - w0), 64'd1);
    check("sd_wr_size",  64'(last_size),       64'd3);
    check("sd_wr_data",  last_wdata,           64'h1122_3344_5566_7788);
    check("sd_wr_addr",  last_addr,            64'h2008);

    // Faults never reach memory
    s0 = strobes;
    exp_q.push_back(mk(4'd3, 64'd0, 1'b1, 1'b0));
    send(1'b0, 3'd1, 64'h2000, 12'd1, 64'd0, 4'd3);
    exp_q.push_back(mk(4'd4, 64'd0, 1'b1, 1'b1));
    send(1'b1, 3'd4, 64'h2000, 12'd0, 64'hDEAD, 4'd4);
    wait_idle();
    check("fault_no_strobe", 64'(strobes - s0), 64'd0);

    // Fill the queue under busy and response backpressure
    bus.resp_ready_i = 1'b0;
    bus.dmem_busy_i  = 1'b1;
    s0 = strobes;
    exp_q.push_back(mk(4'd0, 64'h1122_3344_5566_7788, 1'b0, 1'b0));
    send(1'b0, 3'd3, 64'h2000, 12'd8, 64'd0, 4'd0);
    exp_q.push_back(mk(4'd1, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0));
    send(1'b0, 3'd2, 64'h2000, 12'd4, 64'd0, 4'd1);
    exp_q.push_back(mk(4'd2, 64'h0000_0000_0000_0080, 1'b0, 1'b0));
    send(1'b0, 3'd4, 64'h1000, 12'hFFF, 64'd0, 4'd2);
    exp_q.push_back(mk(4'd3, 64'h0000_0000_0000_8000, 1'b0, 1'b0));
    send(1'b0, 3'd5, 64'h2000, 12'd6, 64'd0, 4'd3);
    check("full_not_ready",  64'(bus.req_ready_o), 64'd0);
    check("busy_no_strobe",  64'(strobes - s0),    64'd0);
    bus.dmem_busy_i = 1'b0;
    repeat (6) tick();
    check("bp_one_strobe",   64'(strobes - s0),    64'd1);
    check("bp_resp_held",    64'(bus.resp_valid_o), 64'd1);
    check("bp_head_tag",     64'(bus.resp_tag_o),   64'd0);
    check("bp_still_full",   64'(bus.req_ready_o), 64'd0);
    bus.resp_ready_i = 1'b1;
    wait_idle();
    check("fill_strobes",    64'(strobes - s0),    64'd4);

    // Flush while WAIT with two entries queued
    mem_lat = 2;
    s0 = strobes;
    send(1'b0, 3'd3, 64'h2000, 12'd8, 64'd0, 4'd7);
    send(1'b0, 3'd3, 64'h2000, 12'd8, 64'd0, 4'd8);
    for (int n = 0; n < 20 && strobes == s0; n++) tick();
    check("flush_reached_wait", 64'(strobes - s0), 64'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("drain_not_empty",  64'(bus.empty_o),      64'd0);
    check("drain_no_resp",    64'(bus.resp_valid_o), 64'd0);
    check("drain_ready",      64'(bus.req_ready_o),  64'd1);
    tick();
    check("flush_empty",      64'(bus.empty_o),      64'd1);
    repeat (4) tick();
    check("flush_no_resp",    64'(bus.resp_valid_o), 64'd0);
    check("flush_no_reissue", 64'(strobes - s0),     64'd1);
    mem_lat = 1;

    // Reset while ISSUE is stalled by busy
    bus.dmem_busy_i = 1'b1;
    send(1'b0, 3'd3, 64'h2000, 12'd8, 64'd0, 4'd9);
    tick();
    check("issue_busy_no_strobe", 64'(bus.dmem_rd_en_o), 64'd0);
    rst = 1'b0;
    tick();
    check("midrst_rd_en",  64'(bus.dmem_rd_en_o), 64'd0);
    check("midrst_wr_en",  64'(bus.dmem_wr_en_o), 64'd0);
    check("midrst_empty",  64'(bus.empty_o),      64'd1);
    check("midrst_ready",  64'(bus.req_ready_o),  64'd1);
    rst = 1'b1;
    bus.dmem_busy_i = 1'b0;
    tick();
    s0 = strobes;
    exp_q.push_back(mk(4'd10, 64'h1122_3344_5566_7788, 1'b0, 1'b0));
    send(1'b0, 3'd3, 64'h2000, 12'd8, 64'd0, 4'd10);
    wait_idle();
    check("post_rst_strobes", 64'(strobes - s0), 64'd1);

    repeat (2) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lsu_queue.md
Name: lsu_queue

Overview:
- Next-generation load/store unit with a DEPTH-entry in-order request queue between dispatch and data memory.
- Adds the following capabilities:
  - buffered requests with tags;
  - full RV64 load/store sizes (byte, half, word, double);
  - misalignment and illegal-funct3 fault detection without a memory access;
  - flush;
  - a valid/ready response channel with backpressure.
- Sits between the issue stage and the dmem port; one memory access is outstanding at a time.

Parameters:
- DATA_WIDTH, 64, address and register data width.
- FETCH_WIDTH, 64, dmem data bus width; must be ≥ DATA_WIDTH.
- DEPTH, 4, request queue entries; power of two, ≥ 2.
- TAG_WIDTH, 4, width of the request tag returned with each response.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request offered
- req_ready_o  out  1  queue can accept (not full)
- req_store_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RISC-V funct3 size/sign code
- req_base_i  in  DATA_WIDTH  base register value
- req_imm_i  in  12  signed offset
- req_data_i  in  DATA_WIDTH  store data
- req_tag_i  in  TAG_WIDTH  request tag
- flush_i  in  1  discard queued and in-flight requests
- dmem_busy_i  in  1  memory cannot take a request this cycle
- dmem_rdy_i  in  1  access complete
- dmem_rd_data_i  in  FETCH_WIDTH  read data, LSB-aligned to the address
- dmem_rd_en_o  out  1  read strobe
- dmem_wr_en_o  out  1  write strobe
- dmem_addr_o  out  DATA_WIDTH  access address
- dmem_wr_size_o  out  2  size code: 0=B, 1=H, 2=W, 3=D
- dmem_wr_data_o  out  FETCH_WIDTH  store data, zero-extended
- resp_valid_o  out  1  response available
- resp_ready_i  in  1  consumer accepts response
- resp_tag_o  out  TAG_WIDTH  tag of the responding request
- resp_data_o  out  DATA_WIDTH  formatted load result; 0 for stores and faults
- resp_fault_o  out  1  misaligned or illegal request
- resp_store_o  out  1  response belongs to a store
- empty_o  out  1  queue empty and FSM IDLE

Behaviour:

Reset (rst low at a clk edge):
- Queue pointers and count return to 0; FSM goes to IDLE.
- Outputs: req_ready_o=1, dmem_rd_en_o=0, dmem_wr_en_o=0, resp_valid_o=0, resp_fault_o=0, empty_o=1.
- Reset mid-access abandons the access; a later dmem_rdy_i is ignored while the FSM is not in WAIT.

Enqueue:
- Occurs on req_valid_i && req_ready_o.
- Address = req_base_i + sign-extended req_imm_i, computed at enqueue and stored, modulo 2^DATA_WIDTH wrap.
- req_ready_o = (count != DEPTH). There is no same-cycle bypass when full.
- Simultaneous enqueue and dequeue when not full leaves count unchanged.

Legality (evaluated on the head entry):
- Loads: funct3 0–6 are legal.
- Stores: funct3 0–3 are legal.
- Alignment: low log2(size) address bits must be 0, with size from funct3[1:0].
- Any violation is a fault.

FSM:
- IDLE: if the head is valid: fault → RESP; else → ISSUE.
- ISSUE: dmem_rd_en_o or dmem_wr_en_o = 1 combinationally while !dmem_busy_i. dmem_addr_o, dmem_wr_size_o (funct3[1:0]) and dmem_wr_data_o come from the head. The strobe is asserted in exactly one cycle (the first non-busy cycle), then → WAIT.
- WAIT: on dmem_rdy_i capture dmem_rd_data_i → RESP.
- RESP: resp_valid_o=1 and all resp_* fields are stable until the handshake. On resp_ready_i: pop the head, → IDLE.
- Minimum load latency: accept at T, strobe at T+2, rdy at T+3, resp_valid at T+4.

Load formatting:
- funct3 0/1/2/3 → sign-extend 8/16/32/64 bits.
- funct3 4/5/6 → zero-extend 8/16/32 bits.

Flush:
- Same cycle: the queue is emptied and req_ready_o is ignored for enqueue.
- From ISSUE or RESP: go to IDLE with no strobe.
- From WAIT: go to a DRAIN state that swallows the pending dmem_rdy_i with no response, then → IDLE.
- Flush has priority over a simultaneous enqueue and over a simultaneous response handshake.

Test Plan:
- LB from base 0x1000, imm -1, memory byte 0x80 → dmem_addr_o=0xFFF, resp_data_o=0xFFFF_FFFF_FFFF_FF80, tag preserved.
- LWU at 0x2004 with data 0x8000_0001; SD of 0x1122334455667788 to 0x2008 → resp_data_o=0x0000_0000_8000_0001; then wr_size=3, wr_data matches, resp_store_o=1.
- LH at 0x2001 → resp_fault_o=1 and resp_data_o=0 with no dmem strobe. SW with funct3=4 → fault.
- Fill 4 requests with resp_ready_i=0 and dmem_busy_i held 3 cycles:
  - req_ready_o=0 after the 4th;
  - a single strobe per access;
  - responses return in order, tags 0..3.
- flush_i during WAIT with 2 entries queued → no response for any entry, the late dmem_rdy_i is swallowed, empty_o=1 two cycles later.
- rst=0 during ISSUE with busy held → strobes drop next cycle, empty_o=1, and a following request completes normally.
